// File: rtl/itu_int_sched_if.sv
// Signal bundle between the ITU interrupt scheduler, the timer request lines and the CPU interrupt port.
// The slave modport is the scheduler's view; the master modport is the driving side (timers/CPU).
interface itu_int_sched_if #(
    parameter int NCH = 5
);
    logic             CE_R;
    logic [NCH-1:0]   IMIA_IRQ;
    logic [NCH-1:0]   IMIB_IRQ;
    logic [NCH-1:0]   OVI_IRQ;
    logic [4*NCH-1:0] ITU_PRIO;
    logic [3:0]       IMASK;
    logic             INT_REQ;
    logic [3:0]       INT_LVL;
    logic [7:0]       INT_VEC;
    logic             INT_ACK;
    logic [4:0]       ACK_SRC;
    logic             ACK_STB;

    modport slave (
        input  CE_R, IMIA_IRQ, IMIB_IRQ, OVI_IRQ, ITU_PRIO, IMASK, INT_ACK,
        output INT_REQ, INT_LVL, INT_VEC, ACK_SRC, ACK_STB
    );

    modport master (
        output CE_R, IMIA_IRQ, IMIB_IRQ, OVI_IRQ, ITU_PRIO, IMASK, INT_ACK,
        input  INT_REQ, INT_LVL, INT_VEC, ACK_SRC, ACK_STB
    );
endinterface

// File: rtl/itu_int_sched.sv
// Interrupt scheduler for the ITU: picks the highest-priority unmasked, unblocked request and runs the CPU handshake.
// Define ITU_INT_RR_EN to break equal-level ties round-robin instead of by fixed source order.
module itu_int_sched #(
    parameter int NCH      = 5,
    parameter int VEC_BASE = 80
) (
    input  logic           CLK,
    input  logic           RST,
    itu_int_sched_if.slave bus
);
    localparam int NSRC = 3 * NCH;
    localparam int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [1:0] {IDLE, ARB, REQ, ACKD} state_e;

    state_e          state_q, state_d;
    logic            int_req_q, int_req_d;
    logic [3:0]      lvl_q, lvl_d;
    logic [7:0]      vec_q, vec_d;
    logic [4:0]      ack_src_q, ack_src_d;
    logic            ack_stb_q, ack_stb_d;
    logic [NSRC-1:0] blk_q, blk_d, blk_set;
    logic [IDXW-1:0] win_q, win_d;
`ifdef ITU_INT_RR_EN
    logic [IDXW-1:0] ptr_q, ptr_d;
`endif

    logic [NSRC-1:0] req_raw;
    logic [NSRC-1:0] elig;
    logic [3:0]      src_prio [NSRC];
    logic            any_elig;
    logic            higher;
    logic [IDXW-1:0] best_idx;
    logic [3:0]      best_lvl;

    // Source index s = 3*ch + src, so ascending index is the fixed tie-break order.
    function automatic logic [4:0] src_code(logic [IDXW-1:0] idx);
        int n;
        n = int'(idx);
        return {3'(n / 3), 2'(n % 3)};
    endfunction

    function automatic logic [7:0] vec_of(logic [IDXW-1:0] idx);
        int n;
        n = int'(idx);
        return 8'(VEC_BASE + 4 * (n / 3) + (n % 3));
    endfunction

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign req_raw[3*c]    = bus.IMIA_IRQ[c];
        assign req_raw[3*c+1]  = bus.IMIB_IRQ[c];
        assign req_raw[3*c+2]  = bus.OVI_IRQ[c];
        assign src_prio[3*c]   = bus.ITU_PRIO[4*c +: 4];
        assign src_prio[3*c+1] = bus.ITU_PRIO[4*c +: 4];
        assign src_prio[3*c+2] = bus.ITU_PRIO[4*c +: 4];
    end

    for (genvar s = 0; s < NSRC; s++) begin : g_elig
        assign elig[s] = req_raw[s] && (src_prio[s] != 4'd0) &&
                         (src_prio[s] > bus.IMASK) && !blk_q[s];
    end

    // Strict '>' keeps the first source found at the top level, so scan order decides ties.
    always_comb begin
        int s;
        logic [IDXW-1:0] sidx;
        s        = 0;
        sidx     = '0;
        any_elig = 1'b0;
        higher   = 1'b0;
        best_idx = '0;
        best_lvl = '0;
        for (int i = 0; i < NSRC; i++) begin
`ifdef ITU_INT_RR_EN
            s = (int'(ptr_q) + i) % NSRC;
`else
            s = i;
`endif
            sidx = IDXW'(s);
            if (elig[sidx] && (!any_elig || (src_prio[sidx] > best_lvl))) begin
                any_elig = 1'b1;
                best_idx = sidx;
                best_lvl = src_prio[sidx];
            end
            if (elig[IDXW'(i)] && (src_prio[IDXW'(i)] > lvl_q)) begin
                higher = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        int_req_d = int_req_q;
        lvl_d     = lvl_q;
        vec_d     = vec_q;
        win_d     = win_q;
        ack_src_d = ack_src_q;
        ack_stb_d = 1'b0;
        blk_set   = '0;
`ifdef ITU_INT_RR_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (any_elig) begin
                    lvl_d     = best_lvl;
                    vec_d     = vec_of(best_idx);
                    win_d     = best_idx;
                    int_req_d = 1'b1;
                    state_d   = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // An accept beats a simultaneous withdrawal: the latched source is acknowledged.
                if (bus.INT_ACK) begin
                    int_req_d      = 1'b0;
                    blk_set[win_q] = 1'b1;
                    ack_src_d      = src_code(win_q);
                    ack_stb_d      = 1'b1;
                    state_d        = ACKD;
`ifdef ITU_INT_RR_EN
                    ptr_d          = (int'(win_q) == NSRC - 1) ? '0 : win_q + 1'b1;
`endif
                end else if (!elig[win_q] || higher) begin
                    int_req_d = 1'b0;
                    state_d   = ARB;
                end
            end
            ACKD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A dropped raw request always releases its block, even in the ack cycle.
        blk_d = (blk_q | blk_set) & req_raw;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            int_req_q <= 1'b0;
            lvl_q     <= '0;
            vec_q     <= '0;
            win_q     <= '0;
            ack_src_q <= '0;
            ack_stb_q <= 1'b0;
            blk_q     <= '0;
`ifdef ITU_INT_RR_EN
            ptr_q     <= '0;
`endif
        end else if (bus.CE_R) begin
            state_q   <= state_d;
            int_req_q <= int_req_d;
            lvl_q     <= lvl_d;
            vec_q     <= vec_d;
            win_q     <= win_d;
            ack_src_q <= ack_src_d;
            ack_stb_q <= ack_stb_d;
            blk_q     <= blk_d;
`ifdef ITU_INT_RR_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign bus.INT_REQ = int_req_q;
    assign bus.INT_LVL = lvl_q;
    assign bus.INT_VEC = vec_q;
    assign bus.ACK_SRC = ack_src_q;
    assign bus.ACK_STB = ack_stb_q;
endmodule

// File: tb/tb_itu_int_sched.sv
// Scoreboard bench for itu_int_sched: directed stimulus queues expected request/ack events, a monitor checks them.
module tb_itu_int_sched;
    localparam int NCH = 5;

    logic CLK = 1'b0;
    logic RST;

    itu_int_sched_if #(.NCH(NCH)) bus ();

    itu_int_sched #(.NCH(NCH), .VEC_BASE(80)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;
    logic [18:0] expq [$];
    logic [4*NCH-1:0] prio_v = '0;
    logic prev_req = 1'b0;
    logic prev_stb = 1'b0;

    function automatic logic [18:0] ev_req(int lvl, int vec);
        return {2'd1, 4'(lvl), 8'(vec), 5'd0};
    endfunction

    function automatic logic [18:0] ev_ack(int src);
        return {2'd2, 4'd0, 8'd0, 5'(src)};
    endfunction

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic mon_ev(string name, logic [18:0] act);
        logic [18:0] e;
        n_vec++;
        if (expq.size() == 0) begin
            n_bad++;
            $display("FAIL %s: got event %h, expected no event", name, act);
        end else begin
            e = expq.pop_front();
            if (act !== e) begin
                n_bad++;
                $display("FAIL %s: got event %h, expected %h", name, act, e);
            end
        end
    endtask

    // Events are the rising edges of INT_REQ and ACK_STB, sampled away from the active edge.
    always @(negedge CLK) begin
        if ((bus.INT_REQ === 1'b1) && !prev_req)
            mon_ev("int_req", {2'd1, bus.INT_LVL, bus.INT_VEC, 5'd0});
        if ((bus.ACK_STB === 1'b1) && !prev_stb)
            mon_ev("ack_stb", {2'd2, 4'd0, 8'd0, bus.ACK_SRC});
        prev_req = (bus.INT_REQ === 1'b1);
        prev_stb = (bus.ACK_STB === 1'b1);
    end

    task automatic cyc(int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_prio(int ch, int p);
        prio_v[4*ch +: 4] = 4'(p);
        bus.ITU_PRIO = prio_v;
    endtask

    task automatic wait_req(string name);
        int k;
        k = 0;
        while ((bus.INT_REQ !== 1'b1) && (k < 20)) begin
            cyc(1);
            k++;
        end
        chk(name, int'(bus.INT_REQ === 1'b1), 1);
    endtask

    task automatic pulse_ack();
        bus.INT_ACK = 1'b1;
        cyc(1);
        bus.INT_ACK = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST          = 1'b1;
        bus.CE_R     = 1'b1;
        bus.IMIA_IRQ = '0;
        bus.IMIB_IRQ = '0;
        bus.OVI_IRQ  = '0;
        bus.ITU_PRIO = '0;
        bus.IMASK    = '0;
        bus.INT_ACK  = 1'b0;
        cyc(2);
        chk("rst_int_req", bus.INT_REQ, 0);
        chk("rst_int_lvl", bus.INT_LVL, 0);
        chk("rst_int_vec", bus.INT_VEC, 0);
        chk("rst_ack_stb", bus.ACK_STB, 0);
        chk("rst_ack_src", bus.ACK_SRC, 0);
        RST = 1'b0;

        // Single source, two-cycle latency, then ack.
        set_prio(2, 5);
        expq.push_back(ev_req(5, 89));
        bus.IMIB_IRQ[2] = 1'b1;
        cyc(1);
        chk("single_lat1", bus.INT_REQ, 0);
        cyc(1);
        chk("single_lat2", bus.INT_REQ, 1);
        chk("single_lvl", bus.INT_LVL, 5);
        chk("single_vec", bus.INT_VEC, 89);
        expq.push_back(ev_ack(9));
        pulse_ack();
        chk("single_req_drop", bus.INT_REQ, 0);
        chk("single_stb", bus.ACK_STB, 1);
        chk("single_src", bus.ACK_SRC, 9);
        cyc(1);
        chk("single_stb_1cyc", bus.ACK_STB, 0);
        bus.IMIB_IRQ[2] = 1'b0;
        cyc(2);

        // Higher priority wins; the loser is presented after the ack.
        set_prio(0, 3);
        set_prio(4, 7);
        expq.push_back(ev_req(7, 98));
        bus.IMIA_IRQ[0] = 1'b1;
        bus.OVI_IRQ[4]  = 1'b1;
        wait_req("prio_req");
        expq.push_back(ev_ack(18));
        expq.push_back(ev_req(3, 80));
        pulse_ack();
        wait_req("prio_next");
        expq.push_back(ev_ack(0));
        pulse_ack();
        bus.IMIA_IRQ[0] = 1'b0;
        bus.OVI_IRQ[4]  = 1'b0;
        cyc(2);

        // Equal level: lowest channel first.
        set_prio(0, 4);
        set_prio(1, 4);
        expq.push_back(ev_req(4, 82));
        bus.OVI_IRQ[0]  = 1'b1;
        bus.IMIA_IRQ[1] = 1'b1;
        wait_req("tie_req");
        expq.push_back(ev_ack(2));
        expq.push_back(ev_req(4, 84));
        pulse_ack();
        wait_req("tie_next");
        expq.push_back(ev_ack(4));
        pulse_ack();
        bus.OVI_IRQ[0]  = 1'b0;
        bus.IMIA_IRQ[1] = 1'b0;
        cyc(2);

        // Mask boundary: level equal to IMASK is held off, one above passes.
        bus.IMASK = 4'd6;
        set_prio(1, 6);
        bus.IMIA_IRQ[1] = 1'b1;
        cyc(6);
        chk("mask_hold", bus.INT_REQ, 0);
        expq.push_back(ev_req(6, 84));
        bus.IMASK = 4'd5;
        wait_req("mask_pass");
        expq.push_back(ev_ack(4));
        pulse_ack();
        bus.IMIA_IRQ[1] = 1'b0;
        bus.IMASK = 4'd0;
        cyc(2);

        // Preemption by a strictly higher level: one-cycle drop, then the new winner.
        set_prio(3, 4);
        expq.push_back(ev_req(4, 92));
        bus.IMIA_IRQ[3] = 1'b1;
        wait_req("preempt_first");
        expq.push_back(ev_req(6, 84));
        bus.IMIA_IRQ[1] = 1'b1;
        cyc(1);
        chk("preempt_drop", bus.INT_REQ, 0);
        cyc(1);
        chk("preempt_req", bus.INT_REQ, 1);
        chk("preempt_vec", bus.INT_VEC, 84);
        chk("preempt_lvl", bus.INT_LVL, 6);
        expq.push_back(ev_ack(4));
        bus.IMIA_IRQ[3] = 1'b0;
        pulse_ack();
        bus.IMIA_IRQ[1] = 1'b0;
        cyc(2);

        // A source held high through its ISR stays blocked until it drops.
        expq.push_back(ev_req(4, 80));
        bus.IMIA_IRQ[0] = 1'b1;
        wait_req("blk_first");
        expq.push_back(ev_ack(0));
        pulse_ack();
        cyc(6);
        chk("blk_hold", bus.INT_REQ, 0);
        bus.IMIA_IRQ[0] = 1'b0;
        cyc(1);
        bus.IMIA_IRQ[0] = 1'b1;
        expq.push_back(ev_req(4, 80));
        cyc(1);
        chk("blk_relat1", bus.INT_REQ, 0);
        cyc(1);
        chk("blk_relat2", bus.INT_REQ, 1);
        expq.push_back(ev_ack(0));
        pulse_ack();
        bus.IMIA_IRQ[0] = 1'b0;
        cyc(2);

        // Withdrawal and ack in the same cycle: the ack is taken.
        expq.push_back(ev_req(5, 90));
        bus.OVI_IRQ[2] = 1'b1;
        wait_req("wd_req");
        expq.push_back(ev_ack(10));
        bus.OVI_IRQ[2] = 1'b0;
        pulse_ack();
        chk("wd_stb", bus.ACK_STB, 1);
        chk("wd_src", bus.ACK_SRC, 10);
        chk("wd_req_drop", bus.INT_REQ, 0);
        cyc(4);
        chk("wd_idle", bus.INT_REQ, 0);

        // Clock enable low freezes the handshake even with INT_ACK asserted.
        expq.push_back(ev_req(7, 97));
        bus.IMIB_IRQ[4] = 1'b1;
        wait_req("ce_req");
        bus.CE_R    = 1'b0;
        bus.INT_ACK = 1'b1;
        cyc(3);
        chk("ce_hold_req", bus.INT_REQ, 1);
        chk("ce_hold_stb", bus.ACK_STB, 0);
        chk("ce_hold_vec", bus.INT_VEC, 97);
        expq.push_back(ev_ack(17));
        bus.CE_R = 1'b1;
        cyc(1);
        bus.INT_ACK = 1'b0;
        chk("ce_ack_stb", bus.ACK_STB, 1);

        // Reset clears the block, so the still-high source is presented again.
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        expq.push_back(ev_req(7, 97));
        wait_req("rst_blk_clear");

        // Reset in the middle of a handshake: no strobe, outputs back to zero.
        RST         = 1'b1;
        bus.INT_ACK = 1'b1;
        bus.IMIB_IRQ[4] = 1'b0;
        cyc(1);
        RST         = 1'b0;
        bus.INT_ACK = 1'b0;
        chk("rst_mid_req", bus.INT_REQ, 0);
        chk("rst_mid_stb", bus.ACK_STB, 0);
        chk("rst_mid_vec", bus.INT_VEC, 0);
        chk("rst_mid_lvl", bus.INT_LVL, 0);
        cyc(3);
        chk("rst_mid_idle", bus.INT_REQ, 0);

`ifdef ITU_INT_RR_EN
        // Round-robin among equal levels after each ack.
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        set_prio(1, 4);
        expq.push_back(ev_req(4, 80));
        bus.IMIA_IRQ[0] = 1'b1;
        bus.IMIA_IRQ[1] = 1'b1;
        wait_req("rr_first");
        expq.push_back(ev_ack(0));
        expq.push_back(ev_req(4, 84));
        bus.IMIA_IRQ[0] = 1'b0;
        pulse_ack();
        bus.IMIA_IRQ[0] = 1'b1;
        cyc(1);
        wait_req("rr_second");
        expq.push_back(ev_ack(4));
        expq.push_back(ev_req(4, 80));
        bus.IMIA_IRQ[1] = 1'b0;
        pulse_ack();
        bus.IMIA_IRQ[1] = 1'b1;
        cyc(1);
        wait_req("rr_third");
        expq.push_back(ev_ack(0));
        bus.IMIA_IRQ[0] = 1'b0;
        bus.IMIA_IRQ[1] = 1'b0;
        pulse_ack();
        cyc(2);
`endif

        cyc(5);
        chk("events_outstanding", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
